// File: rtl/four_bit_accumulator_pkg.sv
// Shared widths and FSM state encoding for the four-bit accumulator.
package four_bit_accumulator_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/FourBitAdder.sv
// Combinational 4-bit ripple adder with carry-in and carry-out.
module FourBitAdder
  import four_bit_accumulator_pkg::*;
(
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  input  logic            C_in,
  output logic [OP_W-1:0] S,
  output logic            C_out
);

  assign {C_out, S} = (OP_W+1)'(A) + (OP_W+1)'(B) + (OP_W+1)'(C_in);

endmodule

// File: rtl/four_bit_accumulator.sv
// Sums NUM_OPS 4-bit operands per transaction through FourBitAdder, counting
// every carry-out, and hands the result downstream over valid/ready.
module four_bit_accumulator
  import four_bit_accumulator_pkg::*;
#(
  parameter int unsigned NUM_OPS = 4,
  parameter int unsigned CARRY_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_sum,
  output logic [CARRY_W-1:0] out_carries
);

  state_e               state_q, state_d;
  logic [OP_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CARRY_W-1:0]   carries_q, carries_d;
  logic                 in_ready_d, out_valid_d;
  logic [OP_W-1:0]      out_sum_d;
  logic [CARRY_W-1:0]   out_carries_d;

  logic [OP_W-1:0]      adder_a, adder_s;
  logic                 adder_c;
  logic                 accept;
  logic [CARRY_W:0]     carries_sum;
  logic [CARRY_W-1:0]   carries_inc;
  logic [CNT_W-1:0]     count_inc;

  // The first operand of a transaction starts from zero, later ones from acc.
  assign adder_a = (state_q == ACC) ? acc_q : '0;

  FourBitAdder u_adder (
    .A     (adder_a),
    .B     (in_op),
    .C_in  (in_cin),
    .S     (adder_s),
    .C_out (adder_c)
  );

  assign accept      = in_valid & in_ready & ((state_q == IDLE) | (state_q == ACC));
  assign count_inc   = count_q + CNT_W'(1);
  assign carries_sum = {1'b0, carries_q} + (CARRY_W+1)'(adder_c);
  assign carries_inc = carries_sum[CARRY_W] ? '1 : carries_sum[CARRY_W-1:0];

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    count_d       = count_q;
    carries_d     = carries_q;
    in_ready_d    = in_ready;
    out_valid_d   = out_valid;
    out_sum_d     = out_sum;
    out_carries_d = out_carries;

    if (clr) begin
      state_d     = IDLE;
      acc_d       = '0;
      count_d     = '0;
      carries_d   = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          if (accept) begin
            acc_d     = adder_s;
            carries_d = CARRY_W'(adder_c);
            count_d   = CNT_W'(1);
            state_d   = ACC;
          end
        end
        ACC: begin
          in_ready_d = 1'b1;
          if (accept) begin
            acc_d     = adder_s;
            carries_d = carries_inc;
            count_d   = count_inc;
            if (count_inc == CNT_W'(NUM_OPS)) begin
              state_d       = OUT;
              in_ready_d    = 1'b0;
              out_valid_d   = 1'b1;
              out_sum_d     = adder_s;
              out_carries_d = carries_inc;
            end
          end
        end
        OUT: begin
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          if (out_ready) begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            count_d     = '0;
            carries_d   = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          count_d     = '0;
          carries_d   = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      carries_q   <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_carries <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      carries_q   <= carries_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_sum     <= out_sum_d;
      out_carries <= out_carries_d;
    end
  end

endmodule

// File: tb/tb_four_bit_accumulator.sv
// Self-checking bench: transaction-level reference model plus directed and random stimulus.
module tb_four_bit_accumulator;

  localparam int unsigned NUM_OPS = 4;
  localparam int unsigned CARRY_W = 3;
  localparam int          CAR_MAX = (1 << CARRY_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_op = '0;
  logic               in_cin = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         out_sum;
  logic [CARRY_W-1:0] out_carries;

  int n_checks = 0;
  int n_fail   = 0;

  four_bit_accumulator #(.NUM_OPS(NUM_OPS), .CARRY_W(CARRY_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_cin      (in_cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is the arithmetic total of op+cin over NUM_OPS accepts.
  bit m_live    = 1'b0;
  bit m_pending = 1'b0;
  int m_n       = 0;
  int m_total   = 0;
  int m_sum     = 0;
  int m_car     = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_live = 1'b1; m_pending = 1'b0; m_n = 0; m_total = 0;
    end else if (clr) begin
      m_pending = 1'b0; m_n = 0; m_total = 0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 1'b0;
    end else if (in_valid) begin
      m_total += int'(in_op) + int'(in_cin);
      m_n++;
      if (m_n == NUM_OPS) begin
        m_pending = 1'b1;
        m_sum     = m_total % 16;
        m_car     = (m_total / 16 > CAR_MAX) ? CAR_MAX : m_total / 16;
        m_n       = 0;
        m_total   = 0;
      end
    end
  end

  // Per-cycle comparison against the model, half a cycle after each edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("in_ready", int'(in_ready), int'(!m_pending));
      chk("out_valid", int'(out_valid), int'(m_pending));
      if (m_pending) begin
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_carries", int'(out_carries), m_car);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; rst = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic cin);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_cin = cin;
      out_ready = 1'b0; clr = 1'b0; rst = 1'b0;
      done = in_ready;
      @(posedge clk);
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic get_result(output int s, output int c);
    bit got = 1'b0;
    s = -1; c = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      in_valid = 1'b0; clr = 1'b0; rst = 1'b0;
      if (out_valid) begin
        s = int'(out_sum); c = int'(out_carries);
        out_ready = 1'b1; got = 1'b1;
      end else begin
        out_ready = 1'b0;
      end
      @(posedge clk);
    end
    if (!got) chk("result_timeout", 0, 1);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d, input logic cin);
    send(4'(a), cin); send(4'(b), cin); send(4'(c), cin); send(4'(d), cin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_carries", int'(out_carries), 0);
    rst = 1'b0;
    @(posedge clk);

    // Back-to-back 3,8,11,3 -> total 25.
    send4(3, 8, 11, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_out_valid", int'(out_valid), 1);
    @(posedge clk);
    get_result(s, c);
    chk("b2b_sum", s, 9);
    chk("b2b_carries", c, 1);

    // 15 with cin each, four times -> total 64.
    send4(15, 15, 15, 15, 1'b1);
    get_result(s, c);
    chk("max_sum", s, 0);
    chk("max_carries", c, 4);

    // Same operands with bubbles, then downstream stalls for five cycles.
    send(4'd3, 1'b0); idle(2);
    send(4'd8, 1'b0); idle(1);
    send(4'd11, 1'b0); idle(3);
    send(4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); in_op = 4'd7; in_cin = 1'b1; out_ready = 1'b0;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
      chk("hold_sum", int'(out_sum), 9);
      chk("hold_carries", int'(out_carries), 1);
      @(posedge clk);
    end
    get_result(s, c);
    chk("bubble_sum", s, 9);
    chk("bubble_carries", c, 1);

    // Abort after two accepts; the operand offered alongside clr is dropped.
    send(4'd7, 1'b0); send(4'd9, 1'b1);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_op = 4'd5; in_cin = 1'b1;
    @(posedge clk);
    send4(1, 2, 3, 4, 1'b0);
    get_result(s, c);
    chk("clr_sum", s, 10);
    chk("clr_carries", c, 0);

    // Reset while a result is pending.
    send4(5, 6, 7, 8, 1'b0);
    idle(2);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid2", int'(out_valid), 0);
    chk("rst_in_ready2", int'(in_ready), 1);
    @(posedge clk);
    send4(0, 0, 0, 0, 1'b0);
    get_result(s, c);
    chk("zero_sum", s, 0);
    chk("zero_carries", c, 0);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(3) != 0);
      in_op     = 4'($urandom);
      in_cin    = 1'($urandom);
      out_ready = ($urandom_range(2) == 0);
      clr       = ($urandom_range(39) == 0);
      rst       = ($urandom_range(149) == 0);
      @(posedge clk);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
